// File: rtl/dsp_divider_pkg.sv
// Shared definitions for the 32-bit radix-2 restoring divider:
// op encodings, FSM states, widths and the special-case constants.
package dsp_divider_pkg;

    localparam int DATA_W = 32;
    localparam int ITER_N = 32;
    localparam int CNT_W  = 5;

    localparam logic [DATA_W-1:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    function automatic logic op_is_signed(input op_e o);
        return ~o[0];
    endfunction

    function automatic logic op_is_rem(input op_e o);
        return o[1];
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtract for one restoring-division step: 33-bit partial remainder
// minus the zero-extended divisor, with the borrow reported separately.
module div_trial_sub
    import dsp_divider_pkg::*;
(
    input  logic [DATA_W:0]   rem_shifted,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   diff,
    output logic              borrow
);

    logic [DATA_W+1:0] full;

    assign full   = {1'b0, rem_shifted} - {2'b00, divisor};
    assign diff   = full[DATA_W:0];
    assign borrow = full[DATA_W+1];

endmodule

// File: rtl/dsp_divider.sv
// RV32M-style divider: 32 restoring iterations on magnitudes, then sign fixup.
// Divide-by-zero and signed overflow bypass the iterations and finish in one cycle.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, 32 cycles
// FIXUP | apply signs, register result
// DONE  | done pulse; a new start may be accepted here
module dsp_divider
    import dsp_divider_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] div_q, div_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [DATA_W:0]   rem_shifted;
    logic [DATA_W:0]   diff;
    logic              borrow;
    logic              diff_msb_unused;

    op_e               op_in;
    logic              in_signed;
    logic              in_rem;
    logic              div_zero;
    logic              overflow;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [DATA_W-1:0] special_res;

    assign rem_shifted = {rem_q, quo_q[DATA_W-1]};

    div_trial_sub u_trial (
        .rem_shifted (rem_shifted),
        .divisor     (div_q),
        .diff        (diff),
        .borrow      (borrow)
    );

    // When no borrow occurs the difference is below the divisor, so bit 32 is always zero.
    assign diff_msb_unused = diff[DATA_W];

    assign op_in     = op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_rem    = op_is_rem(op_in);
    assign div_zero  = (divisor == '0);
    assign overflow  = in_signed && (dividend == INT_MIN) && (divisor == ALL_ONES);
    assign abs_a     = (in_signed && dividend[DATA_W-1]) ? -dividend : dividend;
    assign abs_b     = (in_signed && divisor[DATA_W-1])  ? -divisor  : divisor;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = in_rem ? dividend : ALL_ONES;
        end else begin
            special_res = in_rem ? '0 : INT_MIN;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        div_d    = div_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    op_d = op_in;
                    if (div_zero || overflow) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end else begin
                        div_d   = abs_b;
                        rem_d   = '0;
                        quo_d   = abs_a;
                        cnt_d   = '0;
                        qneg_d  = in_signed && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        rneg_d  = in_signed && dividend[DATA_W-1];
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = borrow ? rem_shifted[DATA_W-1:0] : diff[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], ~borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER_N - 1)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                if (op_is_rem(op_q)) begin
                    result_d = rneg_q ? -rem_q : rem_q;
                end else begin
                    result_d = qneg_q ? -quo_q : quo_q;
                end
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_DIV;
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_CALC) || (state_q == ST_FIXUP);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_dsp_divider.sv
// Directed bench for dsp_divider: a vector table of operations with expected
// result and latency, plus sequences for ignored start, back-to-back and reset abort.
module tb_dsp_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_tests;
    int n_fail;

    dsp_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive a start for one edge, then scramble the operand inputs.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = ~o;
        dividend = ~a;
        divisor  = b + 32'd3;
    endtask

    // Latency counted from the accepting edge: 1 means done right after it.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        int lat;
        logic seen_done;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        vecs[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
        vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[9]  = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34};
        vecs[10] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34};
        vecs[11] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        vecs[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        vecs[13] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
        vecs[14] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  34};
        vecs[15] = '{2'b11, 32'd3,          32'd5,          32'd3,          34};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_result_held", i), result, vecs[i].exp);
        end

        // Start pulsed while busy must be ignored.
        launch(2'b01, 32'd100, 32'd7);
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == 10) begin
                op       = 2'b11;
                dividend = 32'd1000;
                divisor  = 32'd3;
                start    = 1'b1;
            end else begin
                start    = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        if (!done) lat = -1;
        check("ignore_start_latency", 32'(lat), 32'd34);
        check("ignore_start_result",  result,   32'd14);
        @(posedge clk);
        #1;

        // Back-to-back: start during the done cycle.
        launch(2'b01, 32'd100, 32'd7);
        wait_done(lat);
        check("b2b_first_latency", 32'(lat), 32'd34);
        check("b2b_first_result",  result,   32'd14);
        launch(2'b11, 32'd100, 32'd7);
        check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        check("b2b_result_held",   result,        32'd14);
        wait_done(lat);
        check("b2b_second_latency", 32'(lat), 32'd34);
        check("b2b_second_result",  result,   32'd2);
        @(posedge clk);
        #1;

        // Reset at cycle 20 aborts the operation.
        launch(2'b01, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1;
        check("abort_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_done",   {31'd0, done}, 32'd0);
        check("abort_result", result,        32'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        launch(2'b00, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        check("after_abort_latency", 32'(lat), 32'd34);
        check("after_abort_result",  result,   32'hFFFF_FFFD);
        @(posedge clk);
        #1;

        // Reset wins over a simultaneous start.
        op       = 2'b01;
        dividend = 32'd5;
        divisor  = 32'd0;
        start    = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        check("rst_prio_done",   {31'd0, done}, 32'd0);
        check("rst_prio_result", result,        32'd0);
        @(posedge clk);
        #1;
        check("rst_prio_idle", {30'd0, busy, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
